sysid_reader_master: RTL

SYSID_READER_MASTER -- requirements
Module: sysid_reader_master

---
 rtl/sysid_reader_pkg.sv | 15 +
 rtl/sysid_reader_timer.sv | 31 +++
 rtl/sysid_reader_master.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sysid_reader_pkg.sv
// Shared types and constants for the sysid reader master and its timeout timer.
package sysid_reader_pkg;
    localparam int          CNT_W                      = 8;
    localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd2;
    localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1713793819;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        WAIT_ID,
        RD_TS,
        WAIT_TS,
        DONE
    } state_e;
endpackage

// File: rtl/sysid_reader_timer.sv
// Per-phase cycle counter; expired flags the last permitted cycle of the phase.
module sysid_reader_timer
    import sysid_reader_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);
    logic [CNT_W-1:0] count_q, count_d;

    // Counts cycles already spent, so a limit of N allows exactly N cycles.
    assign expired = enable && (count_q == limit - CNT_W'(1));

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (enable && !expired)
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end
endmodule

// File: rtl/sysid_reader_master.sv
// Reads sysid id (addr 0) then timestamp (addr 1) over Avalon-MM and flags matches.
module sysid_reader_master
    import sysid_reader_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);
    state_e      state_q, state_d;
    logic        avm_read_q, avm_read_d, avm_address_q, avm_address_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d, ts_value_q, ts_value_d;
    logic        in_phase, advance, expired;

    assign in_phase = (state_q == RD_ID) || (state_q == WAIT_ID) ||
                      (state_q == RD_TS) || (state_q == WAIT_TS);
    // Any phase hand-off restarts the timer so each phase gets its own budget.
    assign advance  = (((state_q == RD_ID) || (state_q == RD_TS)) && !avm_waitrequest) ||
                      (((state_q == WAIT_ID) || (state_q == WAIT_TS)) && avm_readdatavalid);

    sysid_reader_timer u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!in_phase || advance),
        .enable  (in_phase),
        .limit   (CNT_W'(TIMEOUT_CYCLES)),
        .expired (expired)
    );

    always_comb begin
        state_d       = state_q;
        avm_read_d    = avm_read_q;
        avm_address_d = avm_address_q;
        id_ok_d       = id_ok_q;
        ts_ok_d       = ts_ok_q;
        timeout_d     = timeout_q;
        id_value_d    = id_value_q;
        ts_value_d    = ts_value_q;
        case (state_q)
            IDLE: if (start) begin
                state_d       = RD_ID;
                avm_read_d    = 1'b1;
                avm_address_d = 1'b0;
                id_ok_d       = 1'b0;
                ts_ok_d       = 1'b0;
                timeout_d     = 1'b0;
                id_value_d    = '0;
                ts_value_d    = '0;
            end
            RD_ID, RD_TS: if (advance) begin
                state_d    = (state_q == RD_ID) ? WAIT_ID : WAIT_TS;
                avm_read_d = 1'b0;
            end
            WAIT_ID: if (advance) begin
                state_d       = RD_TS;
                id_value_d    = avm_readdata;
                avm_read_d    = 1'b1;
                avm_address_d = 1'b1;
            end
            WAIT_TS: if (advance) begin
                state_d       = DONE;
                ts_value_d    = avm_readdata;
                avm_address_d = 1'b0;
                id_ok_d       = (id_value_q == EXPECTED_ID);
                ts_ok_d       = (avm_readdata == EXPECTED_TIMESTAMP);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Progress on the final permitted cycle wins over the timeout.
        if (in_phase && !advance && expired) begin
            state_d       = DONE;
            timeout_d     = 1'b1;
            avm_read_d    = 1'b0;
            avm_address_d = 1'b0;
            id_ok_d       = 1'b0;
            ts_ok_d       = 1'b0;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            avm_read_q    <= 1'b0;
            avm_address_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            timeout_q     <= 1'b0;
            id_value_q    <= '0;
            ts_value_q    <= '0;
        end else begin
            state_q       <= state_d;
            avm_read_q    <= avm_read_d;
            avm_address_q <= avm_address_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            id_ok_q       <= id_ok_d;
            ts_ok_q       <= ts_ok_d;
            timeout_q     <= timeout_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
        end
    end

    assign avm_read    = avm_read_q;
    assign avm_address = avm_address_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;
endmodule
